direction_button_conditioner: RTL and testbench
===============================================

// Module: direction_button_conditioner
// PURPOSE
//  Conditions the four raw, asynchronous direction pushbuttons into the clean
//  one-hot command vector direction_a consumed by the direction FSM.
//  - synchronises each button and debounces it;
//  - emits a single-cycle one-hot pulse per debounced press.
//  Sits between the board button pins and the direction FSM, in the same
//  clk domain.
// PARAMETERS
//  SYNC_STAGES      2        synchroniser flops per button (>=2)
//  DEBOUNCE_CYCLES  250000   cycles a level must be stable to be accepted (>=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width (derived, localparam)
// PORTS
//  clk          in   1  system clock
//  nrst         in   1  asynchronous active-low reset
//  btn_raw      in   4  raw buttons, active-high: [0]=LEFT [1]=RIGHT [2]=DOWN [3]=UP
//  direction_a  out  4  one-hot press pulse, same bit map; 4'b0000 = no command
//  press        out  1  high in the same cycle direction_a is non-zero
// BEHAVIOUR
//  Interface (decided): one clock, clk. Reset nrst is asynchronous and
//  active-low.
//  Reset: all sync flops, channel FSMs (IDLE), counters, direction_a=4'b0000
//  and press=0 are cleared immediately on nrst low. Reset mid-debounce discards
//  the partial count; no pulse is emitted for that press.
//  Sync: btn_raw[i] passes SYNC_STAGES flops -> s[i]. No logic is placed
//  before the first flop.
//  Per-channel FSM (4 independent copies), counter cnt is CNT_W bits:
//   IDLE:    s=1 -> PRESS_WAIT, cnt<=0.
//   PRESS_WAIT: s=0 -> IDLE (bounce rejected). Else, if
//            cnt==DEBOUNCE_CYCLES-1 -> HELD, assert rise for 1 cycle;
//            else cnt++.
//   HELD:    s=0 -> RELEASE_WAIT, cnt<=0. Holding emits no further rise.
//   RELEASE_WAIT: s=1 -> HELD (release bounce; no new rise). Else, if
//            cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
//  Counters never wrap: cnt is only compared against DEBOUNCE_CYCLES-1.
//  Output stage (registered):
//   - exactly one rise[i] high -> direction_a<=one-hot(i), press<=1;
//   - zero or >=2 rises in the same cycle -> direction_a<=0, press<=0
//     (ambiguous simultaneous press is dropped, never merged).
//   - Outputs are 0 in every other cycle, so each is a 1-cycle pulse.
//  Latency: btn_raw stable high from before edge 0 -> pulse visible after edge
//  SYNC_STAGES+DEBOUNCE_CYCLES+1, lasting exactly one cycle.
//  Independence: a press on channel j while channel i is HELD is accepted
//  normally.
// STRUCTURE
//  Shared package: 4-bit codes BTN_LEFT=4'b0001, BTN_RIGHT=4'b0010,
//  BTN_DOWN=4'b0100, BTN_UP=4'b1000, and the channel state enum
//  (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT). direction_t stays as is in the
//  package.
//  Sub-module: debounce_channel.
//   - contains the synchroniser, FSM and counter for one button;
//   - outputs rise;
//   - instantiated 4x by generate.
//  Top level holds only the one-hot/ambiguity check and the output registers.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 -> latency 7)
//  1. Clean press: btn_raw=0001 held from edge 0 -> direction_a=0001 and
//     press=1 after edge 7 only; 0 afterwards while held.
//  2. Bounce: btn_raw[1] toggles 1,1,0,1,0 (each < 4 cycles), then 0
//     -> no pulse ever.
//  3. Release/repress:
//     - UP held 20 cycles, released 10 cycles, held again
//       -> exactly two 1000 pulses;
//     - a 1-cycle low glitch during the hold -> still exactly one pulse.
//  4. Simultaneous: btn_raw 0000->0011 in one cycle -> direction_a stays 0000
//     and press stays 0. DOWN pressed while LEFT held -> one 0100 pulse.
//  5. Reset mid-op: btn_raw=0100 held, nrst pulsed low at edge 4 (async,
//     between edges) -> outputs 0 at once, no pulse; the press is then
//     re-detected 7 edges after nrst deasserts.
//  6. Random bursts vs a reference model: pulses are always one-hot,
//     one cycle wide, and one per accepted press.

Source files
------------

// File: rtl/direction_button_conditioner_pkg.sv
// Shared types for the direction button conditioner: button codes, the
// per-channel debounce state encoding and a one-hot test.
package direction_button_conditioner_pkg;

    localparam int NUM_BTN = 4;

    typedef logic [NUM_BTN-1:0] direction_t;

    localparam direction_t BTN_LEFT  = 4'b0001;
    localparam direction_t BTN_RIGHT = 4'b0010;
    localparam direction_t BTN_DOWN  = 4'b0100;
    localparam direction_t BTN_UP    = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } chan_state_e;

    function automatic logic is_onehot(input direction_t v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/direction_button_conditioner_debounce_channel.sv
// One button channel: synchroniser, press/release debounce FSM and a
// registered single-cycle rise pulse on each accepted press.
module debounce_channel
    import direction_button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    output logic rise
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    chan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   s;

    // Raw pin goes straight into the first flop.
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high returns to HELD without a new press.
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/direction_button_conditioner.sv
// Four debounced button channels feeding a registered one-hot command pulse;
// simultaneous presses are ambiguous and dropped.
module direction_button_conditioner
    import direction_button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_BTN-1:0]  btn_raw,
    output logic [NUM_BTN-1:0]  direction_a,
    output logic                press
);

    direction_t rise;
    direction_t dir_q, dir_d;
    logic       press_q, press_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .nrst   (nrst),
            .btn_raw(btn_raw[i]),
            .rise   (rise[i])
        );
    end

    always_comb begin
        press_d = is_onehot(rise);
        dir_d   = press_d ? rise : '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dir_q   <= '0;
            press_q <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            press_q <= press_d;
        end
    end

    assign direction_a = dir_q;
    assign press       = press_q;

endmodule

// File: tb/tb_direction_button_conditioner.sv
// Bench for direction_button_conditioner with a short debounce window; a
// run-length reference model feeds a per-cycle expectation queue.
module tb_direction_button_conditioner;
    import direction_button_conditioner_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] btn_raw;
    logic [3:0] direction_a;
    logic       press;

    int ncmp  = 0;
    int nfail = 0;

    direction_button_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .btn_raw    (btn_raw),
        .direction_a(direction_a),
        .press      (press)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the synchronised input has differed
    // from the accepted level for DEB+1 consecutive edges.
    logic [SYNC-1:0] m_sync [4];
    logic [3:0]      m_deb, m_rise;
    int              m_run [4];
    logic [4:0]      exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sync[i] = '0;
            m_run[i]  = 0;
        end
        m_deb  = '0;
        m_rise = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] b);
        logic [4:0] out;
        logic [3:0] nr;
        if (!nrst) begin
            for (int i = 0; i < 4; i++) begin
                m_sync[i] = '0;
                m_run[i]  = 0;
            end
            m_deb  = '0;
            m_rise = '0;
            exp_q.push_back(5'b0);
        end else begin
            out = ($countones(m_rise) == 1) ? {m_rise, 1'b1} : 5'b0;
            nr  = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_sync[i][SYNC-1] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_deb[i] = m_sync[i][SYNC-1];
                        m_run[i] = 0;
                        nr[i]    = m_deb[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_sync[i] = {m_sync[i][SYNC-2:0], b[i]};
            end
            m_rise = nr;
            exp_q.push_back(out);
        end
    endtask

    // Drives b for the next posedge and returns at the following negedge.
    task automatic drive(input logic [3:0] b);
        btn_raw = b;
        model_step(b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] e;
        nrst    = 1'b0;
        btn_raw = 4'b0000;
        model_reset();
        #1;
        ncmp++;
        if ({direction_a, press} !== 5'b0) begin
            nfail++;
            $display("FAIL reset_now: dir=%b press=%b, want 0000/0", direction_a, press);
        end
        for (int k = 0; k < 6; k++) begin
            drive((k < 4) ? 4'b1111 : 4'b0000);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e || e !== 5'b0) begin
                nfail++;
                $display("FAIL reset_hold k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
        end
        nrst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(4'b0000);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL reset_after k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] e;
        int np = 0, at = -1;
        for (int k = 0; k < 24; k++) begin
            drive((k < 16) ? BTN_LEFT : 4'b0000);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL clean k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press) begin
                np++;
                at = k;
            end
        end
        ncmp++;
        if (np != 1 || at != SYNC + DEB + 1) begin
            nfail++;
            $display("FAIL clean_latency: %0d pulses last at edge %0d, want 1 at edge %0d", np, at, SYNC + DEB + 1);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] e;
        logic [21:0] pat = 22'b0000000000_0101100111;
        int np = 0;
        for (int k = 0; k < 22; k++) begin
            drive({2'b00, pat[k], 1'b0});
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL bounce k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press) np++;
        end
        ncmp++;
        if (np != 0) begin
            nfail++;
            $display("FAIL bounce_count: %0d pulses, want 0", np);
        end
    endtask

    task automatic test_release_repress();
        logic [4:0] e;
        logic [3:0] b;
        int np = 0;
        for (int k = 0; k < 62; k++) begin
            b = (k < 20 || (k >= 30 && k < 50)) ? BTN_UP : 4'b0000;
            drive(b);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL repress k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press && direction_a == BTN_UP) np++;
        end
        ncmp++;
        if (np != 2) begin
            nfail++;
            $display("FAIL repress_count: %0d UP pulses, want 2", np);
        end
        np = 0;
        for (int k = 0; k < 33; k++) begin
            b = (k < 21 && k != 10) ? BTN_UP : 4'b0000;
            drive(b);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL glitch k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press) np++;
        end
        ncmp++;
        if (np != 1) begin
            nfail++;
            $display("FAIL glitch_count: %0d pulses, want 1", np);
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] e;
        logic [3:0] b;
        int np = 0, nl = 0, nd = 0;
        for (int k = 0; k < 24; k++) begin
            drive((k < 12) ? (BTN_LEFT | BTN_RIGHT) : 4'b0000);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL simul k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press || direction_a != 4'b0000) np++;
        end
        ncmp++;
        if (np != 0) begin
            nfail++;
            $display("FAIL simul_count: %0d active cycles, want 0", np);
        end
        for (int k = 0; k < 40; k++) begin
            b = (k < 28) ? BTN_LEFT : 4'b0000;
            if (k >= 12 && k < 24) b = b | BTN_DOWN;
            drive(b);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL indep k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press && direction_a == BTN_LEFT) nl++;
            if (press && direction_a == BTN_DOWN) nd++;
        end
        ncmp++;
        if (nl != 1 || nd != 1) begin
            nfail++;
            $display("FAIL indep_count: left=%0d down=%0d, want 1 and 1", nl, nd);
        end
    endtask

    task automatic test_reset_midop();
        logic [4:0] e;
        int np = 0, at = -1;
        for (int k = 0; k < 5; k++) begin
            drive(BTN_DOWN);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL midop_pre k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press) np++;
        end
        #2 nrst = 1'b0;
        #1;
        ncmp++;
        if ({direction_a, press} !== 5'b0) begin
            nfail++;
            $display("FAIL midop_async: dir=%b press=%b, want 0000/0", direction_a, press);
        end
        model_reset();
        drive(BTN_DOWN);
        e = exp_q.pop_front();
        ncmp++;
        if ({direction_a, press} !== e) begin
            nfail++;
            $display("FAIL midop_inrst: dir=%b press=%b, want %b", direction_a, press, e);
        end
        nrst = 1'b1;
        for (int k = 0; k < 24; k++) begin
            drive((k < 14) ? BTN_DOWN : 4'b0000);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL midop_post k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press) begin
                np++;
                at = k;
            end
        end
        ncmp++;
        if (np != 1 || at != SYNC + DEB + 1) begin
            nfail++;
            $display("FAIL midop_redetect: %0d pulses last at edge %0d, want 1 at edge %0d", np, at, SYNC + DEB + 1);
        end
    endtask

    task automatic test_random();
        logic [4:0] e;
        logic [3:0] b = 4'b0000;
        logic [3:0] prev = 4'b0000;
        int hold [4] = '{0, 0, 0, 0};
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    b[i]    = ~b[i];
                    hold[i] = $urandom_range(1, 14);
                end
                hold[i]--;
            end
            drive((k < 780) ? b : 4'b0000);
            e = exp_q.pop_front();
            ncmp++;
            if ({direction_a, press} !== e) begin
                nfail++;
                $display("FAIL random k=%0d: dir=%b press=%b, want %b", k, direction_a, press, e);
            end
            if (press !== (direction_a != 4'b0000) || (press && !is_onehot(direction_a))) begin
                nfail++;
                $display("FAIL random_onehot k=%0d: dir=%b press=%b, want one-hot with press", k, direction_a, press);
            end
            if (direction_a != 4'b0000 && direction_a == prev) begin
                nfail++;
                $display("FAIL random_width k=%0d: dir=%b repeated, want 1-cycle pulse", k, direction_a);
            end
            prev = direction_a;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_repress();
        test_simultaneous();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
